// File: rtl/motor_ramp.sv
// motor_ramp: slew-rate limiter between a duty/direction command and a
// downstream motor_controller.
//   CLOCK_50      sole clock, rising edge
//   reset         synchronous, active-high
//   target_valid  one-cycle strobe latching target_dir / target_duty
//   target_dir    requested direction (1 = forward, 0 = reverse)
//   target_duty   requested duty, 0..1023
//   out_enable    motor enable (dropped only during a dead interval)
//   out_dir       applied direction
//   out_duty      slew-limited duty, one step of at most STEP per tick
//   busy          outputs have not yet settled on the latched target
// Optional feature: define MOTOR_RAMP_DEADTIME_EN to insert DEAD_CYCLES of
// disabled output on every direction reversal.
module motor_ramp #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned STEP        = 8,
  parameter int unsigned DEAD_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       target_valid,
  input  logic       target_dir,
  input  logic [9:0] target_duty,
  output logic       out_enable,
  output logic       out_dir,
  output logic [9:0] out_duty,
  output logic       busy
);

  if (TICK_DIV == 0 || TICK_DIV > 65535 || STEP == 0 || STEP > 1023 ||
      DEAD_CYCLES == 0 || DEAD_CYCLES > 65535) begin : g_param_check
    $error("motor_ramp: parameter out of range");
  end

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [9:0]  STEP_D    = 10'(STEP);
  localparam logic [10:0] STEP_W    = {1'b0, STEP_D};

  logic [15:0] prescale;
  logic        tick;
  logic        run_tick;
  logic        lat_dir;
  logic [9:0]  lat_duty;

  logic [10:0] duty_w;
  logic [10:0] lat_w;
  logic [10:0] up_sum;
  logic [9:0]  dn_duty;
  logic [9:0]  toward_duty;
  logic [9:0]  brake_duty;

`ifdef MOTOR_RAMP_DEADTIME_EN
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

  typedef enum logic {RUN, DEAD} state_t;

  state_t      state;
  logic [15:0] dead_cnt;

  assign run_tick = tick && (state == RUN);
  assign busy     = (out_duty != lat_duty) || (out_dir != lat_dir) || (state == DEAD);
`else
  assign run_tick   = tick;
  assign out_enable = 1'b1;
  assign busy       = (out_duty != lat_duty) || (out_dir != lat_dir);
`endif

  assign tick = (prescale == TICK_LAST);

  // 11-bit step arithmetic; results are clamped to the target (or 0) so
  // out_duty can never wrap. dn_duty is only selected when out_duty >= STEP.
  always_comb begin
    duty_w  = {1'b0, out_duty};
    lat_w   = {1'b0, lat_duty};
    up_sum  = duty_w + STEP_W;
    dn_duty = out_duty - STEP_D;

    brake_duty = (duty_w > STEP_W) ? dn_duty : '0;

    if (lat_w > duty_w)
      toward_duty = (up_sum > lat_w) ? lat_duty : up_sum[9:0];
    else if (duty_w < lat_w + STEP_W)
      toward_duty = lat_duty;
    else
      toward_duty = dn_duty;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      prescale <= '0;
      lat_dir  <= 1'b1;
      lat_duty <= '0;
      out_duty <= '0;
      out_dir  <= 1'b1;
`ifdef MOTOR_RAMP_DEADTIME_EN
      state      <= RUN;
      out_enable <= 1'b1;
      dead_cnt   <= '0;
`endif
    end else begin
      prescale <= tick ? '0 : prescale + 16'd1;

      // Step decisions use the target latched before this edge, so a strobe
      // only influences the first tick after it.
      if (target_valid) begin
        lat_dir  <= target_dir;
        lat_duty <= target_duty;
      end

      if (run_tick) begin
        if (out_dir == lat_dir) begin
          out_duty <= toward_duty;
        end else if (out_duty != '0) begin
          out_duty <= brake_duty;
        end else begin
`ifdef MOTOR_RAMP_DEADTIME_EN
          state      <= DEAD;
          out_enable <= 1'b0;
          dead_cnt   <= '0;
`else
          out_dir <= lat_dir;
`endif
        end
      end

`ifdef MOTOR_RAMP_DEADTIME_EN
      if (state == DEAD) begin
        if (dead_cnt == DEAD_LAST) begin
          state      <= RUN;
          out_enable <= 1'b1;
          out_dir    <= lat_dir;
        end else begin
          dead_cnt <= dead_cnt + 16'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_motor_ramp.sv
// tb_motor_ramp: self-checking bench for motor_ramp with TICK_DIV=4, STEP=8,
// DEAD_CYCLES=10. Honours MOTOR_RAMP_DEADTIME_EN the same way as the design.
module tb_motor_ramp;

  localparam int TD = 4;
  localparam int ST = 8;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       target_valid = 1'b0;
  logic       target_dir = 1'b1;
  logic [9:0] target_duty = '0;
  logic       out_enable;
  logic       out_dir;
  logic [9:0] out_duty;
  logic       busy;
  logic [12:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  int m_pre;
  int m_lat_duty;
  int m_duty;
  int m_dead_left;
  bit m_lat_dir;
  bit m_dir;
  bit m_en;

  always #5 clk = ~clk;

  motor_ramp #(
    .TICK_DIV   (TD),
    .STEP       (ST),
    .DEAD_CYCLES(DC)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .target_valid(target_valid),
    .target_dir  (target_dir),
    .target_duty (target_duty),
    .out_enable  (out_enable),
    .out_dir     (out_dir),
    .out_duty    (out_duty),
    .busy        (busy)
  );

  assign dut_vec = {out_enable, out_dir, out_duty, busy};

  function automatic logic [12:0] model_vec();
    bit b;
    b = (m_duty != m_lat_duty) || (m_dir != m_lat_dir) || (m_dead_left > 0);
    return {m_en, m_dir, 10'(m_duty), b};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge(input bit rst, input bit v, input bit d, input int du);
    bit tk;
    int diff;
    if (rst) begin
      m_pre = 0; m_lat_duty = 0; m_lat_dir = 1'b1;
      m_duty = 0; m_dir = 1'b1; m_en = 1'b1; m_dead_left = 0;
      return;
    end
    tk = (m_pre == TD - 1);
    m_pre = (m_pre + 1) % TD;
    if (m_dead_left > 0) begin
      m_dead_left--;
      if (m_dead_left == 0) begin
        m_en  = 1'b1;
        m_dir = m_lat_dir;
      end
    end else if (tk) begin
      if (m_dir == m_lat_dir) begin
        diff = m_lat_duty - m_duty;
        if (diff > 0) m_duty += imin(ST, diff);
        else          m_duty -= imin(ST, -diff);
      end else if (m_duty > 0) begin
        m_duty -= imin(ST, m_duty);
      end else begin
`ifdef MOTOR_RAMP_DEADTIME_EN
        m_en = 1'b0;
        m_dead_left = DC;
`else
        m_dir = m_lat_dir;
`endif
      end
    end
    if (v) begin
      m_lat_dir  = d;
      m_lat_duty = du;
    end
  endtask

  // Drive one clock of stimulus, advance the model, settle past the edge.
  task automatic cycle(input bit rst, input bit v, input bit d, input int du);
    reset        = rst;
    target_valid = v;
    target_dir   = d;
    target_duty  = 10'(du);
    @(posedge clk);
    model_edge(rst, v, d, du);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 0, 500);
    vectors++;
    if (dut_vec !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_held: got %h required %h", dut_vec, {1'b1, 1'b1, 10'd0, 1'b0});
    end
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (dut_vec !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_release cyc %0d: got %h required %h", i, dut_vec, {1'b1, 1'b1, 10'd0, 1'b0});
      end
    end
  endtask

  task automatic test_ramp_up();
    int exp_up[13] = '{8, 16, 24, 32, 40, 48, 56, 64, 72, 80, 88, 96, 100};
    int q[$];
    int at[$];
    int prev;
    cycle(1, 0, 0, 0);
    prev = 0;
    cycle(0, 1, 1, 100);
    for (int i = 0; i < 60; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL ramp_up cyc %0d: got %h required %h", i, dut_vec, model_vec());
      end
      if (int'(out_duty) != prev) begin
        q.push_back(int'(out_duty));
        at.push_back(i);
        prev = int'(out_duty);
      end
    end
    vectors++;
    if (q.size() != 13) begin
      miscompares++;
      $display("FAIL ramp_up_steps: got %0d steps required 13", q.size());
    end
    for (int i = 0; i < 13 && i < q.size(); i++) begin
      vectors++;
      if (q[i] != exp_up[i]) begin
        miscompares++;
        $display("FAIL ramp_up_value %0d: got %0d required %0d", i, q[i], exp_up[i]);
      end
      if (i > 0) begin
        vectors++;
        if (at[i] - at[i-1] != TD) begin
          miscompares++;
          $display("FAIL ramp_up_spacing %0d: got %0d required %0d", i, at[i] - at[i-1], TD);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_up_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_clamp();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 1020);
    for (int i = 0; i < 700 && m_duty != 1020; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL clamp_up cyc %0d: got %h required %h", i, dut_vec, model_vec());
      end
    end
    vectors++;
    if (out_duty !== 10'd1020) begin
      miscompares++;
      $display("FAIL clamp_reach_1020: got %0d required 1020", out_duty);
    end
    cycle(0, 1, 1, 1023);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    vectors++;
    if (out_duty !== 10'd1023 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_1023: got duty %0d busy %b required 1023 busy 0", out_duty, busy);
    end
    cycle(0, 1, 1, 5);
    for (int i = 0; i < 700 && m_duty != 5; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL clamp_down cyc %0d: got %h required %h", i, dut_vec, model_vec());
      end
    end
    vectors++;
    if (out_duty !== 10'd5) begin
      miscompares++;
      $display("FAIL clamp_reach_5: got %0d required 5", out_duty);
    end
    cycle(0, 1, 1, 0);
    for (int i = 0; i < TD; i++) cycle(0, 0, 0, 0);
    vectors++;
    if (out_duty !== 10'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_zero: got duty %0d busy %b required 0 busy 0", out_duty, busy);
    end
  endtask

  task automatic test_reversal();
    int exp_rev[8] = '{32, 24, 16, 8, 0, 8, 16, 24};
    int q[$];
    int prev;
    int en_low;
    int exp_low;
`ifdef MOTOR_RAMP_DEADTIME_EN
    exp_low = DC;
`else
    exp_low = 0;
`endif
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 40);
    for (int i = 0; i < 40 && (m_duty != 40); i++) cycle(0, 0, 0, 0);
    vectors++;
    if (out_duty !== 10'd40 || out_dir !== 1'b1) begin
      miscompares++;
      $display("FAIL rev_start: got duty %0d dir %b required 40 dir 1", out_duty, out_dir);
    end
    prev = 40;
    en_low = 0;
    cycle(0, 1, 0, 24);
    for (int i = 0; i < 60; i++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL reversal cyc %0d: got %h required %h", i, dut_vec, model_vec());
      end
      if (out_enable === 1'b0) en_low++;
      if (int'(out_duty) != prev) begin
        q.push_back(int'(out_duty));
        prev = int'(out_duty);
      end
    end
    vectors++;
    if (q.size() != 8) begin
      miscompares++;
      $display("FAIL rev_steps: got %0d steps required 8", q.size());
    end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      vectors++;
      if (q[i] != exp_rev[i]) begin
        miscompares++;
        $display("FAIL rev_value %0d: got %0d required %0d", i, q[i], exp_rev[i]);
      end
    end
    vectors++;
    if (en_low != exp_low) begin
      miscompares++;
      $display("FAIL rev_dead_len: got %0d required %0d", en_low, exp_low);
    end
    vectors++;
    if (out_dir !== 1'b0 || out_enable !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rev_end: got dir %b en %b busy %b required 0 1 0", out_dir, out_enable, busy);
    end
  endtask

  task automatic test_retarget();
    int q[$];
    int prev;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 200);
    for (int i = 0; i < 60 && m_duty != 48; i++) cycle(0, 0, 0, 0);
    vectors++;
    if (out_duty !== 10'd48) begin
      miscompares++;
      $display("FAIL retarget_start: got %0d required 48", out_duty);
    end
    prev = 48;
    cycle(0, 1, 1, 64);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL retarget cyc %0d: got %h required %h", i, dut_vec, model_vec());
      end
      if (int'(out_duty) != prev) begin
        q.push_back(int'(out_duty));
        prev = int'(out_duty);
      end
      cycle(0, 0, 0, 0);
    end
    vectors++;
    if (q.size() != 2 || q[0] != 56 || q[1] != 64) begin
      miscompares++;
      $display("FAIL retarget_seq: got %0d steps first %0d required 2 steps 56,64",
               q.size(), (q.size() > 0) ? q[0] : -1);
    end
    vectors++;
    if (out_duty !== 10'd64 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL retarget_hold: got duty %0d busy %b required 64 busy 0", out_duty, busy);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 100);
    for (int i = 0; i < 60 && m_duty != 48; i++) cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 300);
    vectors++;
    if (dut_vec !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got %h required %h", dut_vec, {1'b1, 1'b1, 10'd0, 1'b0});
    end
    for (int i = 0; i < 2 * TD; i++) cycle(0, 0, 0, 0);
    vectors++;
    if (dut_vec !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_hold: got %h required %h", dut_vec, {1'b1, 1'b1, 10'd0, 1'b0});
    end
`ifdef MOTOR_RAMP_DEADTIME_EN
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 2 * TD && m_en; i++) cycle(0, 0, 0, 0);
    vectors++;
    if (out_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dead_entry: got en %b required 0", out_enable);
    end
    cycle(1, 0, 0, 0);
    vectors++;
    if (dut_vec !== {1'b1, 1'b1, 10'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_dead_abort: got %h required %h", dut_vec, {1'b1, 1'b1, 10'd0, 1'b0});
    end
`endif
  endtask

  task automatic test_random();
    bit rst;
    bit v;
    int du;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      v   = ($urandom_range(0, 24) == 0) || (i % 500 < 3);
      case ($urandom_range(0, 3))
        0:       du = $urandom_range(0, 15);
        1:       du = $urandom_range(1008, 1023);
        default: du = $urandom_range(0, 1023);
      endcase
      cycle(rst, v, 1'($urandom_range(0, 1)), du);
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h required %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp();
    test_reversal();
    test_retarget();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motor_ramp.md
MOTOR_RAMP -- requirements
Module: motor_ramp

Interface
REQ-001: Parameter TICK_DIV, default 50000, meaning clock cycles per ramp step; legal range 1..65535.
REQ-002: Parameter STEP, default 8, meaning maximum duty change per ramp step; legal range 1..1023.
REQ-003: Parameter DEAD_CYCLES, default 50000, meaning enable-low cycles on direction reversal; legal range 1..65535.
REQ-004: CLOCK_50  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: target_valid  input  1  one-cycle strobe; loads target_dir and target_duty.
REQ-007: target_dir  input  1  requested direction: 1 = forward, 0 = reverse.
REQ-008: target_duty  input  10  requested duty, 0..1023.
REQ-009: out_enable  output  1  enable to the downstream motor_controller.
REQ-010: out_dir  output  1  direction to the downstream motor_controller.
REQ-011: out_duty  output  10  slew-limited duty to the downstream motor_controller.
REQ-012: busy  output  1  high while the outputs differ from the latched target.

Function
REQ-013: A target_valid cycle SHALL latch target_dir and target_duty at that clock edge; the newest strobe SHALL win, including mid-ramp.
REQ-014: A 16-bit prescaler SHALL count 0..TICK_DIV-1 and wrap, free-running from reset; a tick SHALL occur in the cycle where it equals TICK_DIV-1.
REQ-015: States SHALL be RUN and DEAD; DEAD SHALL exist only when the macro is defined.
REQ-016: RUN, tick, out_dir equal to latched dir: out_duty SHALL move toward the latched duty by min(STEP, |difference|).
REQ-017: RUN, tick, out_dir not equal to latched dir, out_duty > 0: out_duty SHALL decrease by min(STEP, out_duty).
REQ-018: RUN, tick, out_dir not equal to latched dir, out_duty == 0: behaviour SHALL follow REQ-026/REQ-027.
REQ-019: Step arithmetic SHALL use 11 bits with a clamp to 0..1023; out_duty SHALL never wrap.
REQ-020: Outside RUN-with-tick cycles, out_duty and out_dir SHALL hold.
REQ-021: busy SHALL be combinational: (out_duty != latched duty) OR (out_dir != latched dir) OR (state == DEAD).
REQ-022: Latency: a strobe at cycle N SHALL have its first effect on out_duty at the first tick after cycle N.

Reset
REQ-023: While reset is high, the following SHALL hold at the next edge: out_duty = 0, out_dir = 1, out_enable = 1, latched duty = 0, latched dir = 1, prescaler = 0, state = RUN.
REQ-024: Reset SHALL override target_valid in the same cycle, and SHALL abort any ramp or DEAD interval immediately.
REQ-025: After reset is released, busy SHALL read 0.

Configuration
REQ-026: With MOTOR_RAMP_DEADTIME_EN defined, the REQ-018 condition SHALL enter DEAD with out_enable = 0 for exactly DEAD_CYCLES cycles. It SHALL then set out_dir to the latched dir, set out_enable = 1, and return to RUN. Ticks SHALL be ignored during DEAD.
REQ-027: Without MOTOR_RAMP_DEADTIME_EN, the REQ-018 condition SHALL set out_dir to the latched dir at that tick. out_enable SHALL be constant 1, and no DEAD state or counter SHALL be synthesized.

Verification (TICK_DIV=4, STEP=8, DEAD_CYCLES=10)
REQ-028: Reset pulse -> out_duty 0, out_dir 1, out_enable 1, busy 0.
REQ-029: Strobe fwd/100 from 0 -> out_duty 8,16,...,96,100 at ticks 4 cycles apart (13 ticks); busy falls after 100 is reached.
REQ-030: Ramp at 1020 with target 1023 -> 1023, no overflow. Then target 0 from out_duty 5 -> 0 in one tick.
REQ-031: At fwd/40, strobe rev/24 -> 32,24,16,8,0. With the macro: out_enable low 10 cycles, then out_dir 0, then 8,16,24. Without the macro: out_dir 0 at the zero tick, then 8,16,24.
REQ-032: Mid-ramp at 48 toward 200, strobe 64 -> 56,64, then hold with busy 0.
REQ-033: Reset asserted at out_duty 48 -> next edge out_duty 0, out_dir 1, latched duty 0, busy 0. Any DEAD interval is aborted with out_enable 1.
